button_conditioner: RTL and testbench

// - Input-side counterpart of the VGA/7-seg output path: turns a raw, bouncy, asynchronous

---
 rtl/button_conditioner.sv | 168 ++++++++++++++++
 tb/tb_button_conditioner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, registered press/release pulses
// and a press counter. Optional auto-repeat of up_pulse while held is enabled by FLAP_REPEAT_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 30_000_000,
  parameter int REPEAT_PERIOD   = 15_000_000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       up_pulse,
  output logic       release_pulse,
  output logic [7:0] press_cnt,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // cnt holds the number of stable s2 samples already seen; the DEBOUNCE_CYCLES-th one accepts.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  if (REPEAT_PERIOD < 2 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_repeat
    $error("button_conditioner: need REPEAT_DELAY >= REPEAT_PERIOD >= 2");
  end

  logic             s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             up_q, up_d;
  logic             rel_q, rel_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

`ifdef FLAP_REPEAT_EN
  // The repeat counter is sized from REPEAT_DELAY itself so CNT_W only has to cover the debounce.
  localparam int RPT_W = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    up_d        = 1'b0;
    rel_d       = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (s2_q) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d     = S_PRESSED;
          level_d     = 1'b1;
          up_d        = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (!s2_q) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      S_RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = S_IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

`ifdef FLAP_REPEAT_EN
    // Counts held cycles in PRESSED; reload makes later pulses REPEAT_PERIOD apart.
    rpt_d = '0;
    if (state_q == S_PRESSED && s2_q) begin
      if (rpt_q == RPT_FIRE) begin
        rpt_d = RPT_RELOAD;
        up_d  = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_ONE;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      up_q        <= 1'b0;
      rel_q       <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      up_q        <= up_d;
      rel_q       <= rel_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef FLAP_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign btn_level     = level_q;
  assign up_pulse      = up_q;
  assign release_pulse = rel_q;
  assign press_cnt     = press_cnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Repeat expectations follow FLAP_REPEAT_EN as defined for this compile.
module tb_button_conditioner;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd2;

  logic       clk;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic       up_pulse;
  logic       release_pulse;
  logic [7:0] press_cnt;
  logic [1:0] state_dbg;

  int n_checks;
  int n_fail;
  int up_seen;
  int rel_seen;
  int base_up;
  int base_rel;
  int exp_repeats;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (21)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .up_pulse     (up_pulse),
    .release_pulse(release_pulse),
    .press_cnt    (press_cnt),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (up_pulse === 1'b1) up_seen++;
    if (release_pulse === 1'b1) rel_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    up_seen     = 0;
    rel_seen    = 0;
`ifdef FLAP_REPEAT_EN
    exp_repeats = 11;
`else
    exp_repeats = 0;
`endif
    rst     = 1'b1;
    btn_raw = 1'b0;
    ticks(3);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_up", 32'(up_pulse), 32'd0);
    chk("rst_rel", 32'(release_pulse), 32'd0);
    chk("rst_cnt", 32'(press_cnt), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // clean press: next edge is edge 0
    rst     = 1'b0;
    btn_raw = 1'b1;
    ticks(5);
    chk("press_e4_up", 32'(up_pulse), 32'd0);
    chk("press_e4_level", 32'(btn_level), 32'd0);
    tick();
    chk("press_e5_up", 32'(up_pulse), 32'd1);
    chk("press_e5_level", 32'(btn_level), 32'd1);
    chk("press_e5_cnt", 32'(press_cnt), 32'd1);
    tick();
    chk("press_e6_up", 32'(up_pulse), 32'd0);

    // clean release
    btn_raw = 1'b0;
    ticks(5);
    chk("rel_e4_rel", 32'(release_pulse), 32'd0);
    chk("rel_e4_level", 32'(btn_level), 32'd1);
    tick();
    chk("rel_e5_rel", 32'(release_pulse), 32'd1);
    chk("rel_e5_level", 32'(btn_level), 32'd0);
    tick();
    chk("rel_e6_rel", 32'(release_pulse), 32'd0);
    chk("rel_up_total", 32'(up_seen), 32'd1);
    chk("rel_rel_total", 32'(rel_seen), 32'd1);

    // bounce: 2 high / 2 low for 20 cycles
    base_up = up_seen;
    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b1;
      ticks(2);
      btn_raw = 1'b0;
      ticks(2);
    end
    ticks(10);
    chk("bounce_up", 32'(up_seen - base_up), 32'd0);
    chk("bounce_level", 32'(btn_level), 32'd0);
    chk("bounce_cnt", 32'(press_cnt), 32'd1);

    // second press, then a 2-cycle low glitch while pressed
    btn_raw = 1'b1;
    ticks(7);
    chk("press2_cnt", 32'(press_cnt), 32'd2);
    chk("press2_level", 32'(btn_level), 32'd1);
    base_rel = rel_seen;
    btn_raw  = 1'b0;
    ticks(2);
    btn_raw = 1'b1;
    ticks(10);
    chk("glitch_rel", 32'(rel_seen - base_rel), 32'd0);
    chk("glitch_level", 32'(btn_level), 32'd1);
    chk("glitch_state", 32'(state_dbg), 32'(ST_PRESSED));
    btn_raw = 1'b0;
    ticks(7);
    chk("rel2_level", 32'(btn_level), 32'd0);
    chk("rel2_rel", 32'(rel_seen - base_rel), 32'd1);

    // reset asserted mid-cycle while pressed
    btn_raw = 1'b1;
    ticks(7);
    chk("press3_cnt", 32'(press_cnt), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_level", 32'(btn_level), 32'd0);
    chk("midrst_cnt", 32'(press_cnt), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    rst     = 1'b0;
    base_up = up_seen;
    ticks(5);
    chk("postrst_e4_up", 32'(up_pulse), 32'd0);
    tick();
    chk("postrst_e5_up", 32'(up_pulse), 32'd1);
    chk("postrst_e5_cnt", 32'(press_cnt), 32'd1);

    // hold after acceptance: repeats at +10, +13, ... only with FLAP_REPEAT_EN
    ticks(9);
    chk("hold_a9_up", 32'(up_pulse), 32'd0);
    tick();
    chk("hold_a10_up", 32'(up_pulse), 32'(exp_repeats != 0));
    tick();
    chk("hold_a11_up", 32'(up_pulse), 32'd0);
    ticks(2);
    chk("hold_a13_up", 32'(up_pulse), 32'(exp_repeats != 0));
    ticks(28);
    chk("hold_up_total", 32'(up_seen - base_up), 32'(1 + exp_repeats));
    chk("hold_cnt", 32'(press_cnt), 32'd1);
    btn_raw = 1'b0;
    ticks(8);

    // wrap: 256 clean presses from zero
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    base_up = up_seen;
    for (int i = 0; i < 256; i++) begin
      btn_raw = 1'b1;
      ticks(7);
      btn_raw = 1'b0;
      ticks(7);
      if (i == 254) chk("wrap_cnt_255", 32'(press_cnt), 32'd255);
    end
    chk("wrap_cnt", 32'(press_cnt), 32'd0);
    chk("wrap_up_total", 32'(up_seen - base_up), 32'd256);
    chk("wrap_level", 32'(btn_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
